// File: rtl/dsk_pkg.sv
// Shared types and constants for the floppy sector bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dsk_pkg;

   // Bridge controller states.
   typedef enum logic [2:0] {
      IDLE,
      CALC,
      CHECK,
      SD_REQ,
      SD_XFER,
      FINISH
   } state_t;

   // Completion status codes reported with done.
   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_RNF     = 2'd1;
   localparam logic [1:0] ERR_WP      = 2'd2;
   localparam logic [1:0] ERR_NOMEDIA = 2'd3;

   // One sector of the raw image; buffer depth and address width follow from it.
   localparam int SECTOR_BYTES = 512;
   localparam int SECTOR_AW    = $clog2(SECTOR_BYTES);

endpackage

// File: rtl/dsk_sector_bridge_if.sv
// mist_io SD block-transfer bus between the sector bridge and mist_io.
// Latency: n/a (wiring only).
// Backpressure: sd_rd/sd_wr are held until sd_ack; sd_ack frames the whole transfer.
interface dsk_sector_bridge_if;

   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout;
   logic [7:0]  sd_buff_din;
   logic        sd_buff_wr;

   // Bridge side: issues block requests and supplies write data.
   modport master (
      output sd_lba, sd_rd, sd_wr, sd_buff_din,
      input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
   );

   // mist_io side: acknowledges requests and streams the buffer.
   modport slave (
      input  sd_lba, sd_rd, sd_wr, sd_buff_din,
      output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
   );

endinterface

// File: rtl/dsk_sector_ram.sv
// 512x8 true dual-port sector buffer, port A = FDC, port B = mist_io.
// Latency: both read ports registered, data one cycle after the address.
// Backpressure: none; always accepts. Build option DSK_WRITE_EN keeps the port-B read path.
module dsk_sector_ram
   import dsk_pkg::*;
(
   input  logic                 clk_i,
   input  logic [SECTOR_AW-1:0] a_addr_i,
   input  logic [7:0]           a_din_i,
   input  logic                 a_we_i,
   output logic [7:0]           a_dout_o,
   input  logic [SECTOR_AW-1:0] b_addr_i,
   input  logic [7:0]           b_din_i,
   input  logic                 b_we_i,
   output logic [7:0]           b_dout_o
);

   logic [7:0] mem_q [SECTOR_BYTES];
   logic [7:0] a_dout_q;

   // Storage writes; the bridge guarantees the two ports never write in the same cycle.
   always_ff @(posedge clk_i) begin
      if (a_we_i) mem_q[a_addr_i] <= a_din_i;
      if (b_we_i) mem_q[b_addr_i] <= b_din_i;
   end

   // FDC-side registered read.
   always_ff @(posedge clk_i) begin
      a_dout_q <= mem_q[a_addr_i];
   end

   assign a_dout_o = a_dout_q;

`ifdef DSK_WRITE_EN
   logic [7:0] b_dout_q;

   // SD-side registered read, only needed when sectors are written back to the image.
   always_ff @(posedge clk_i) begin
      b_dout_q <= mem_q[b_addr_i];
   end

   assign b_dout_o = b_dout_q;
`else
   assign b_dout_o = 8'h00;
`endif

endmodule

// File: rtl/dsk_sector_bridge.sv
// FDC single-sector read/write to mist_io SD block transfer, owning a 512-byte buffer.
// Latency: req->done 3 cycles on error paths; otherwise CALC+CHECK+SD handshake+FINISH.
// Backpressure: requests outside IDLE are dropped; sd_rd/sd_wr held until sd_ack. Option: DSK_WRITE_EN.
module dsk_sector_bridge
   import dsk_pkg::*;
#(
   parameter int SPT    = 10,
   parameter int TRACKS = 40,
   parameter int SIDES  = 1
) (
   input  logic                       clk_sys,
   input  logic                       reset,
   input  logic                       req_rd,
   input  logic                       req_wr,
   input  logic [6:0]                 trk,
   input  logic                       side,
   input  logic [7:0]                 sec,
   output logic                       busy,
   output logic                       done,
   output logic [1:0]                 err,
   input  logic [8:0]                 fdc_addr,
   input  logic [7:0]                 fdc_din,
   input  logic                       fdc_we,
   output logic [7:0]                 fdc_dout,
   input  logic                       img_mounted,
   input  logic                       img_readonly,
   input  logic [63:0]                img_size,
   dsk_sector_bridge_if.master        sd
);

`ifdef DSK_WRITE_EN
   localparam bit WR_BUILT = 1'b1;
`else
   localparam bit WR_BUILT = 1'b0;
`endif

   state_t      state_q, state_d;
   logic [1:0]  err_q, err_d;
   logic [6:0]  trk_q;
   logic        side_q;
   logic [7:0]  sec_q;
   logic        wr_q;
   logic [31:0] lba_q;
   logic        ack_q;
   logic        mounted_q;
   logic        ro_q;
   logic [31:0] nblocks_q;
   logic [31:0] lba_calc;
   logic        range_bad;
   logic        sd_rd_c;
   logic        sd_wr_c;
   logic        sd_buf_we;

   // Linear image: track-major, then side, then sector.
   assign lba_calc  = ((32'(trk_q) * 32'(SIDES)) + 32'(side_q)) * 32'(SPT) + 32'(sec_q);
   assign range_bad = ({24'b0, sec_q} >= 32'(SPT))    ||
                      ({25'b0, trk_q} >= 32'(TRACKS)) ||
                      ({31'b0, side_q} >= 32'(SIDES)) ||
                      (lba_q >= nblocks_q);

   // Mount state follows every img_mounted pulse, even mid-transfer.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         mounted_q <= 1'b0;
         ro_q      <= 1'b1;
         nblocks_q <= '0;
      end else if (img_mounted) begin
         mounted_q <= (img_size != 64'd0);
         ro_q      <= img_readonly;
         nblocks_q <= img_size[40:9];
      end
   end

   // State register.
   always_ff @(posedge clk_sys) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Request latch, block address, status and ack edge history.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         trk_q  <= '0;
         side_q <= 1'b0;
         sec_q  <= '0;
         wr_q   <= 1'b0;
         lba_q  <= '0;
         err_q  <= ERR_OK;
         ack_q  <= 1'b0;
      end else begin
         ack_q <= sd.sd_ack;
         err_q <= err_d;
         if (state_q == IDLE && (req_rd || req_wr)) begin
            trk_q  <= trk;
            side_q <= side;
            sec_q  <= sec;
            wr_q   <= req_wr && !req_rd;   // read wins a tie
         end
         if (state_q == CALC) lba_q <= lba_calc;
      end
   end

   // Next state and completion status.
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         IDLE:    if (req_rd || req_wr) state_d = CALC;
         CALC:    state_d = CHECK;
         CHECK: begin
            if (!mounted_q) begin
               state_d = FINISH;
               err_d   = ERR_NOMEDIA;
            end else if (range_bad) begin
               state_d = FINISH;
               err_d   = ERR_RNF;
            end else if (wr_q && (ro_q || !WR_BUILT)) begin
               state_d = FINISH;
               err_d   = ERR_WP;
            end else begin
               state_d = SD_REQ;
            end
         end
         SD_REQ:  if (sd.sd_ack) state_d = SD_XFER;
         SD_XFER: begin
            if (ack_q && !sd.sd_ack) begin
               state_d = FINISH;
               err_d   = ERR_OK;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status and SD request strobes decoded from the current state.
   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      sd_rd_c = 1'b0;
      sd_wr_c = 1'b0;
      case (state_q)
         CALC, CHECK, SD_XFER: busy = 1'b1;
         SD_REQ: begin
            busy    = 1'b1;
            sd_rd_c = !wr_q;
            sd_wr_c = wr_q && WR_BUILT;
         end
         FINISH:  done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   assign err       = err_q;
   assign sd.sd_lba = lba_q;
   assign sd.sd_rd  = sd_rd_c;
   assign sd.sd_wr  = sd_wr_c;

   // mist_io may only fill the buffer during the data phase of a read.
   assign sd_buf_we = !reset && (state_q == SD_XFER) && !wr_q && sd.sd_buff_wr;

   dsk_sector_ram u_ram (
      .clk_i    (clk_sys),
      .a_addr_i (fdc_addr),
      .a_din_i  (fdc_din),
      .a_we_i   (fdc_we && !busy),
      .a_dout_o (fdc_dout),
      .b_addr_i (sd.sd_buff_addr),
      .b_din_i  (sd.sd_buff_dout),
      .b_we_i   (sd_buf_we),
      .b_dout_o (sd.sd_buff_din)
   );

endmodule
